decoder_1to2: RTL and testbench
===============================

DECODER_1TO2 -- requirements
Module: decoder_1to2

Interface
REQ-001 Parameter REG_OUT, default 1: 1 selects registered outputs, 0 selects combinational outputs.
REQ-002 Parameter CNT_W, default 8: width of the input-transition counter (legal range 2..32).
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n; port order is o1, o0, i, then the ports below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 o1  output  1  decoded line 1; high when selected input is 1.
REQ-007 o0  output  1  decoded line 0; high when selected input is 0.
REQ-008 i  input  1  select input.
REQ-009 en  input  1  decode enable; low forces o1=o0=0.
REQ-010 vld  output  1  high when {o1,o0} reflects an enabled decode.
REQ-011 cnt  output  CNT_W  count of sampled i transitions; present only with DECODER_1TO2_CNT_EN.

Function
REQ-012 Decode truth table with en=1: i=0 -> {o1,o0}=01; i=1 -> {o1,o0}=10.
REQ-013 With en=0: {o1,o0}=00 and vld=0, regardless of i.
REQ-014 With en=1, {o1,o0} SHALL be exactly one-hot; the codes 11 and 00 never occur.
REQ-015 REG_OUT=1: o1, o0 and vld SHALL update on the rising clk edge from the i and en values sampled at that edge (1-cycle latency).
REQ-016 REG_OUT=0: o1, o0 and vld SHALL follow i and en combinationally (0 latency), but are forced to 0 while rst_n=0.
REQ-017 vld = en under REG_OUT=0, and en delayed one cycle under REG_OUT=1.
REQ-018 The block SHALL register i every cycle into i_q; a transition is i != i_q at a rising edge.
REQ-019 The first sample after reset release SHALL NOT count as a transition.
REQ-020 The transition counter SHALL count transitions regardless of en.
REQ-021 The counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-022 If en changes and i toggles at the same edge, the two effects are independent: the decode follows REQ-012/013 and the counter increments.

Reset
REQ-023 While rst_n=0, outputs SHALL be o1=0, o0=0, vld=0 and cnt=0, asynchronously and in both REG_OUT modes.
REQ-024 While rst_n=0, i_q and the first-sample flag SHALL be cleared.
REQ-025 Reset asserted mid-operation SHALL clear outputs immediately, without waiting for a clock edge.
REQ-026 After rst_n deasserts, the first valid registered decode SHALL appear at the first rising edge after deassertion.

Configuration
REQ-027 Macro DECODER_1TO2_CNT_EN defined: the cnt port and transition counter (REQ-018..021) are compiled in.
REQ-028 Macro DECODER_1TO2_CNT_EN undefined: the cnt port, i_q, the first-sample flag and the counter logic are absent; decode behaviour is unchanged.

Verification
REQ-029 Reset, then en=1, i=0 for 1 cycle -> {o1,o0}=01 and vld=1 one edge later (REG_OUT=1).
REQ-030 en=1, i steps 0->1 -> {o1,o0} goes 01->10 one edge later; cnt increments by 1.
REQ-031 en=0 with i toggled 3 times -> {o1,o0}=00 and vld=0 throughout; cnt increases by 3.
REQ-032 CNT_W=2, i toggled 5 times -> cnt reads 1,2,3,3,3 (saturates at 3).
REQ-033 rst_n pulsed low between clock edges while {o1,o0}=10 -> outputs 00, vld=0 and cnt=0 immediately; after release, the first edge with en=1, i=1 gives 10 and cnt stays 0.
REQ-034 REG_OUT=0, en=1, i toggled between edges -> {o1,o0} tracks i with zero latency (i=0 gives 01, i=1 gives 10).

Source files
------------

// File: rtl/decoder_1to2.sv
// 1-to-2 line decoder with enable, registered or combinational outputs (REG_OUT).
// Optional input-transition counter compiled in with DECODER_1TO2_CNT_EN.
module decoder_1to2 #(
  parameter bit REG_OUT = 1'b1,
  parameter int CNT_W   = 8
) (
  output logic             o1,
  output logic             o0,
  input  logic             i,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             vld
`ifdef DECODER_1TO2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  logic dec1, dec0;

  assign dec1 = en & i;
  assign dec0 = en & ~i;

  generate
    if (REG_OUT) begin : g_reg
      logic o1_q, o0_q, vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o1_q  <= 1'b0;
          o0_q  <= 1'b0;
          vld_q <= 1'b0;
        end else begin
          o1_q  <= dec1;
          o0_q  <= dec0;
          vld_q <= en;
        end
      end

      assign o1  = o1_q;
      assign o0  = o0_q;
      assign vld = vld_q;
    end else begin : g_comb
      // Gate with rst_n so the outputs read zero for the whole reset window.
      assign o1  = rst_n & dec1;
      assign o0  = rst_n & dec0;
      assign vld = rst_n & en;
    end
  endgenerate

`ifdef DECODER_1TO2_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             i_q;
  logic             seen;
  logic [CNT_W-1:0] cnt_q;

  // seen masks the first sample after reset so stale i_q never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q   <= 1'b0;
      seen  <= 1'b0;
      cnt_q <= '0;
    end else begin
      i_q  <= i;
      seen <= 1'b1;
      if (seen && (i != i_q) && (cnt_q != CNT_MAX))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_decoder_1to2.sv
// Scoreboard bench for decoder_1to2: registered, combinational and CNT_W=2 instances
// share one stimulus stream; expectations are hand-computed directed vectors.
module tb_decoder_1to2;

  logic clk, rst_n, i, en;
  logic o1, o0, vld;
  logic co1, co0, cvld;
  logic so1, so0, svld;
`ifdef DECODER_1TO2_CNT_EN
  logic [7:0] cnt8, ccnt;
  logic [1:0] cnt2;
`endif

  decoder_1to2 #(.REG_OUT(1'b1), .CNT_W(8)) dut (
    .o1(o1), .o0(o0), .i(i), .clk(clk), .rst_n(rst_n), .en(en), .vld(vld)
`ifdef DECODER_1TO2_CNT_EN
    , .cnt(cnt8)
`endif
  );

  decoder_1to2 #(.REG_OUT(1'b0), .CNT_W(8)) dut_comb (
    .o1(co1), .o0(co0), .i(i), .clk(clk), .rst_n(rst_n), .en(en), .vld(cvld)
`ifdef DECODER_1TO2_CNT_EN
    , .cnt(ccnt)
`endif
  );

  decoder_1to2 #(.REG_OUT(1'b1), .CNT_W(2)) dut_sat (
    .o1(so1), .o0(so0), .i(i), .clk(clk), .rst_n(rst_n), .en(en), .vld(svld)
`ifdef DECODER_1TO2_CNT_EN
    , .cnt(cnt2)
`endif
  );

  typedef struct {
    logic       o1, o0, vld;
    logic       co1, co0, cvld;
    logic [7:0] c8;
    logic [1:0] c2;
    string      tag;
  } exp_t;

  exp_t q_edge[$];
  exp_t q_now[$];
  event now_ev;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk({e.tag, " o1"},   8'(o1),   8'(e.o1));
    chk({e.tag, " o0"},   8'(o0),   8'(e.o0));
    chk({e.tag, " vld"},  8'(vld),  8'(e.vld));
    chk({e.tag, " c_o1"}, 8'(co1),  8'(e.co1));
    chk({e.tag, " c_o0"}, 8'(co0),  8'(e.co0));
    chk({e.tag, " c_vld"},8'(cvld), 8'(e.cvld));
`ifdef DECODER_1TO2_CNT_EN
    chk({e.tag, " cnt"},  cnt8,     e.c8);
    chk({e.tag, " cnt2"}, 8'(cnt2), 8'(e.c2));
`endif
  endtask

  // Monitor: registered expectations are resolved just after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (q_edge.size() > 0) compare(q_edge.pop_front());
  end

  // Monitor: mid-cycle expectations (async reset, combinational path).
  initial forever begin
    @(now_ev);
    #1;
    if (q_now.size() > 0) compare(q_now.pop_front());
  end

  task automatic push_edge(input string tag, input logic eo1, eo0, ev,
                           input logic [7:0] c8, input logic [1:0] c2);
    exp_t e;
    e = '{o1:eo1, o0:eo0, vld:ev, co1:eo1, co0:eo0, cvld:ev, c8:c8, c2:c2, tag:tag};
    q_edge.push_back(e);
  endtask

  task automatic step(input string tag, input logic ni, ne, input logic eo1, eo0, ev,
                      input logic [7:0] c8, input logic [1:0] c2);
    @(negedge clk);
    i  = ni;
    en = ne;
    push_edge(tag, eo1, eo0, ev, c8, c2);
  endtask

  task automatic now(input string tag, input logic eo1, eo0, ev, input logic eco1, eco0, ecv,
                     input logic [7:0] c8, input logic [1:0] c2);
    exp_t e;
    e = '{o1:eo1, o0:eo0, vld:ev, co1:eco1, co0:eco0, cvld:ecv, c8:c8, c2:c2, tag:tag};
    q_now.push_back(e);
    -> now_ev;
    #2;
  endtask

  initial begin
    rst_n = 1'b0; i = 1'b1; en = 1'b1;
    #2;
    now("reset", 0,0,0, 0,0,0, 8'd0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; i = 1'b0; en = 1'b1;
    push_edge("first_dec", 0,1,1, 8'd0, 2'd0);
    #1;
    now("release", 0,0,0, 0,1,1, 8'd0, 2'd0);
    //        tag         i  en  o1 o0 vld  cnt    cnt2
    step("rise",          1, 1,  1, 0, 1,   8'd1, 2'd1);
    step("dis_t1",        0, 0,  0, 0, 0,   8'd2, 2'd2);
    step("dis_t2",        1, 0,  0, 0, 0,   8'd3, 2'd3);
    step("dis_t3",        0, 0,  0, 0, 0,   8'd4, 2'd3);
    step("sat",           1, 0,  0, 0, 0,   8'd5, 2'd3);
    step("en_only",       1, 1,  1, 0, 1,   8'd5, 2'd3);
    step("en_and_i",      0, 0,  0, 0, 0,   8'd6, 2'd3);
    step("reen",          1, 1,  1, 0, 1,   8'd7, 2'd3);
    // Async reset pulse between edges while outputs read 10.
    #11;
    rst_n = 1'b0;
    now("mid_rst", 0,0,0, 0,0,0, 8'd0, 2'd0);
    rst_n = 1'b1;
    push_edge("post_rst", 1,0,1, 8'd0, 2'd0);
    now("rst_rel", 0,0,0, 1,0,1, 8'd0, 2'd0);
    step("post_t",        0, 1,  0, 1, 1,   8'd1, 2'd1);
    // Toggle i between edges: only the combinational instance follows.
    #8;
    i = 1'b1;
    now("glitch_hi", 0,1,1, 1,0,1, 8'd1, 2'd1);
    i = 1'b0;
    now("glitch_lo", 0,1,1, 0,1,1, 8'd1, 2'd1);
    push_edge("no_glitch_cnt", 0,1,1, 8'd1, 2'd1);
    step("rise2",         1, 1,  1, 0, 1,   8'd2, 2'd2);
    step("dis_end",       1, 0,  0, 0, 0,   8'd2, 2'd2);
    for (int k = 0; k < 20 && (q_edge.size() > 0 || q_now.size() > 0); k++) @(posedge clk);
    #5;
    if (q_edge.size() > 0 || q_now.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending %0d want 0", q_edge.size() + q_now.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
